// File: rtl/robot_motion_sched.sv
// robot_motion_sched: Moore motion scheduler driven by the distance sensor.
// Phases: IDLE -> FWD (cruise) -> BRAKE -> TURN -> CHECK -> FWD or FAULT.
// Optional sensor watchdog enabled by defining ROBOT_SCHED_WDOG_EN.
module robot_motion_sched #(
    parameter int unsigned DW        = 16,
    parameter int unsigned NEAR_TH   = 100,
    parameter int unsigned FAR_TH    = 200,
    parameter int unsigned STOP_CYC  = 4,
    parameter int unsigned TURN_CYC  = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned SPD_FAST  = 200,
    parameter int unsigned SPD_SLOW  = 80,
    parameter int unsigned WDOG_CYC  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] dist_v,
    input  logic          dist_vld,
    output logic [7:0]    speed,
    output logic          turn,
    output logic          fault,
    output logic [7:0]    obst_cnt,
    output logic [2:0]    state_o,
    output logic          wdog_trip
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_BRAKE = 3'd2,
        S_TURN  = 3'd3,
        S_CHECK = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int unsigned TMAX = (STOP_CYC > TURN_CYC) ? STOP_CYC : TURN_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned RW   = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [DW-1:0] NEAR   = DW'(NEAR_TH);
    localparam logic [DW-1:0] FAR    = DW'(FAR_TH);
    localparam logic [TW-1:0] T_STOP = TW'(STOP_CYC - 1);
    localparam logic [TW-1:0] T_TURN = TW'(TURN_CYC - 1);
    localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY - 1);
    localparam logic [7:0]    FAST   = 8'(SPD_FAST);
    localparam logic [7:0]    SLOW   = 8'(SPD_SLOW);

    // Elaboration-time sanity checks on the configuration
    if (FAR_TH <= NEAR_TH) begin : g_bad_th
        $error("FAR_TH must be greater than NEAR_TH");
    end
    if (WDOG_CYC == 0) begin : g_bad_wdog
        $error("WDOG_CYC must be non-zero");
    end

    state_t        state;
    logic [DW-1:0] dist_q;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic          is_obst;
    logic          wdog_fire;

    assign is_obst = dist_vld && (dist_v < NEAR);

`ifdef ROBOT_SCHED_WDOG_EN
    localparam int unsigned WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WW-1:0] wdog_cnt;
    logic          wdog_q;

    assign wdog_fire = en && (state == S_FWD) && !dist_vld &&
                       (wdog_cnt == WW'(WDOG_CYC - 1));
    assign wdog_trip = wdog_q;

    // Count silent FWD cycles; latch the trip flag until the run is disabled
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else if (!en) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if (state != S_FWD || dist_vld || wdog_fire) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_fire) begin
                wdog_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_trip = 1'b0;
`endif

    // Sequencer: state, sample register, phase timer, retry and obstacle count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_IDLE;
            dist_q   <= '0;
            timer    <= '0;
            retry    <= '0;
            obst_cnt <= '0;
        end else begin
            if (dist_vld) begin
                dist_q <= dist_v;
            end

            // Counted independently of the en=0 override so an obstacle seen
            // on the disabling cycle is still recorded.
            if (((state == S_FWD) && is_obst || wdog_fire) && (obst_cnt != 8'hFF)) begin
                obst_cnt <= obst_cnt + 8'd1;
            end

            if (!en && (state != S_IDLE)) begin
                state <= S_IDLE;
                timer <= '0;
                retry <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (en) begin
                            state <= S_FWD;
                            retry <= '0;
                        end
                    end
                    S_FWD: begin
                        retry <= '0;
                        if (is_obst || wdog_fire) begin
                            state <= S_BRAKE;
                            timer <= T_STOP;
                        end
                    end
                    S_BRAKE: begin
                        if (timer == '0) begin
                            state <= S_TURN;
                            timer <= T_TURN;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_TURN: begin
                        if (timer == '0) begin
                            state <= S_CHECK;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (dist_vld) begin
                            if (dist_v >= FAR) begin
                                state <= S_FWD;
                                retry <= '0;
                            end else if (retry == R_LAST) begin
                                state <= S_FAULT;
                            end else begin
                                retry <= retry + 1'b1;
                                state <= S_TURN;
                                timer <= T_TURN;
                            end
                        end
                    end
                    S_FAULT: begin
                        state <= S_FAULT;
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                        retry <= '0;
                    end
                endcase
            end
        end
    end

    // Moore output decode from registered state and the held sample
    always_comb begin
        speed   = '0;
        turn    = 1'b0;
        fault   = 1'b0;
        state_o = state;
        case (state)
            S_FWD: begin
                if (dist_q >= FAR) begin
                    speed = FAST;
                end else if (dist_q >= NEAR) begin
                    speed = SLOW;
                end else begin
                    speed = '0;
                end
            end
            S_TURN: begin
                turn  = 1'b1;
                speed = SLOW;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                speed = '0;
            end
        endcase
    end

endmodule

// File: doc/robot_motion_sched.md
Name: robot_motion_sched

Overview:
- Motion scheduler that sequences the robot drive datapath from the 16-bit distance sensor value `dist_v`.
- Moore FSM with cruise, brake, turn and re-check phases.
- Outputs a speed command, a turn request, an obstacle counter and a fault flag.
- Sits between the sensor front-end and the motor driver; it is the only block that commands motion.

Parameters:
- DW, 16, distance sample width
- NEAR_TH, 100, distance below which an obstacle is declared
- FAR_TH, 200, distance at or above which the path is clear; must be > NEAR_TH
- STOP_CYC, 4, cycles spent in BRAKE
- TURN_CYC, 8, cycles spent in TURN
- MAX_RETRY, 3, consecutive TURN/CHECK rounds allowed before FAULT
- SPD_FAST, 200, 8-bit speed when the path is clear
- SPD_SLOW, 80, 8-bit speed in the caution band and while turning
- WDOG_CYC, 32, sensor-silence limit; used only with the optional feature

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  synchronous active-low reset
- en  in  1  run enable
- dist_v  in  DW  distance sample
- dist_vld  in  1  dist_v valid this cycle
- speed  out  8  speed command
- turn  out  1  turn request
- fault  out  1  stuck, no clear path found
- obst_cnt  out  8  obstacles detected, saturating
- state_o  out  3  encoded FSM state: IDLE=0, FWD=1, BRAKE=2, TURN=3, CHECK=4, FAULT=5
- wdog_trip  out  1  sensor watchdog fired (optional feature)

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-low: `rstn`=0 sampled at a rising edge resets the block.
- Reset values: state IDLE, dist_q=0, timer=0, retry=0, obst_cnt=0, wdog_trip=0. All outputs are therefore 0 after reset.
- dist_q register: loads dist_v on any cycle with dist_vld=1, in every state.
- Output decode: outputs are decoded combinationally from registered state, dist_q and counters only. No input reaches an output combinationally.
- Decision timing: an input sampled at edge N changes state at edge N, so the new outputs are visible in cycle N+1.
- Global rule: en=0 in any state other than IDLE forces IDLE at the next edge. This has priority over every other transition. It also clears fault, retry and timer; obst_cnt is kept.
- IDLE: speed=0, turn=0. en=1 moves to FWD.
- FWD:
  - speed = SPD_FAST if dist_q >= FAR_TH.
  - speed = SPD_SLOW if NEAR_TH <= dist_q < FAR_TH.
  - speed = 0 if dist_q < NEAR_TH.
  - If dist_vld=1 and dist_v < NEAR_TH: go to BRAKE, increment obst_cnt (saturates at 255), load timer=STOP_CYC-1.
  - retry clears on entry to FWD.
- BRAKE: speed=0. Timer decrements each cycle; at timer=0, go to TURN with timer=TURN_CYC-1.
- TURN: turn=1, speed=SPD_SLOW. At timer=0, go to CHECK.
- CHECK:
  - speed=0. Waits any number of cycles for dist_vld=1.
  - dist_v >= FAR_TH: go to FWD.
  - Otherwise, if retry == MAX_RETRY-1: go to FAULT.
  - Otherwise: retry++, go to TURN with timer reloaded.
  - Samples in the band NEAR_TH..FAR_TH-1 count as not clear (hysteresis).
- FAULT: speed=0, fault=1. Only en=0 or reset exits.
- Comparisons are unsigned. Thresholds apply at the exact boundary: dist_v == NEAR_TH is not an obstacle; dist_v == FAR_TH is clear.
- Simultaneous events:
  - dist_vld in BRAKE or TURN updates dist_q only.
  - An obstacle sample arriving in the same cycle as en=0 goes to IDLE, but obst_cnt still increments.
- Reset mid-operation: reset in any state returns to IDLE at the next edge; no command persists.

Optional Feature:
- Macro: ROBOT_SCHED_WDOG_EN.
- When defined:
  - A counter tracks cycles in FWD without dist_vld.
  - When it reaches WDOG_CYC, the FSM goes to BRAKE, treated as an obstacle (obst_cnt++).
  - wdog_trip sets and stays 1 until en=0 or reset.
  - The counter clears on any dist_vld and on leaving FWD.
- When not defined: no counter logic; wdog_trip is tied 0.

Test Plan:
- Reset with rstn=0 for 2 cycles, en=1 -> state_o=0, speed=0, obst_cnt=0 until rstn=1. State FWD one cycle after release.
- en=1, dist_v=250 valid -> speed=200 next cycle. dist_v=150 valid -> speed=80. dist_v=100 valid -> stays FWD, speed=80.
- In FWD, dist_v=50 valid -> BRAKE for 4 cycles with speed=0, then TURN for 8 cycles with turn=1 and speed=80, then CHECK. obst_cnt=1.
- In CHECK, dist_v=150, then 120, then 90 (each after a turn) -> FAULT after the third, fault=1. en=0 -> IDLE next cycle, fault=0, obst_cnt retained.
- In CHECK, dist_v=200 valid -> FWD, speed=200. 256 obstacle events -> obst_cnt holds 255.
- With ROBOT_SCHED_WDOG_EN defined: FWD with no dist_vld for 32 cycles -> BRAKE, wdog_trip=1. Without the macro, same stimulus -> stays FWD, wdog_trip=0.
